// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, D = A - B. It processes one bit per clock,
//   LSB first, through a single full-subtractor cell and a borrow flip-flop.
//   An operation is accepted on a start strobe while idle and runs for exactly
//   WIDTH cycles. Completion is marked by a one-cycle done pulse, when D and
//   Bout are updated together.
//
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous, active-high reset; clears every register
//     start  request; sampled only while idle (busy = 0)
//     A, B   minuend / subtrahend, captured on the accepting edge
//     busy   high while an operation is in progress
//     done   one-cycle pulse: D/Bout were just updated
//     D      registered difference, held until the next completion
//     Bout   final borrow out of the MSB (1 = A < B unsigned), held like D
//     OVF    signed overflow (only with SERIAL_SUB_OVF_EN defined)
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the OVF output. OVF is the
//   borrow into the MSB XOR the borrow out of the MSB. It is captured on the
//   last RUN edge.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             accept;
  logic             last_bit;
  logic [1:0]       fs;
  logic             d_bit;
  logic             borrow_nxt;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bi);
    full_sub = {(~a & b) | (~(a ^ b) & bi), a ^ b ^ bi};
  endfunction

  always_comb begin
    fs         = full_sub(sa[0], sb[0], borrow);
    d_bit      = fs[0];
    borrow_nxt = fs[1];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (state == RUN);
    accept   = (state == IDLE) && start;
    last_bit = (state == RUN) && (count == CW'(WIDTH - 1));
  end

  // Serial datapath: operand capture, bit step, result commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      borrow <= 1'b0;
      count  <= '0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      OVF    <= 1'b0;
`endif
    end else begin
      done <= last_bit;
      if (accept) begin
        sa     <= A;
        sb     <= B;
        borrow <= 1'b0;
        count  <= '0;
      end else if (state == RUN) begin
        sa     <= sa >> 1;
        sb     <= sb >> 1;
        // Difference bits enter at the MSB so the first (LSB) bit lands in
        // sd[0] after WIDTH shifts.
        sd     <= {d_bit, sd[WIDTH-1:1]};
        borrow <= borrow_nxt;
        count  <= count + 1'b1;
      end
      if (last_bit) begin
        D    <= {d_bit, sd[WIDTH-1:1]};
        Bout <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
        // On the last bit, borrow is the borrow into the MSB.
        OVF  <= borrow ^ borrow_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
// Testbench for serial_subtractor (WIDTH = 8): directed steps. Expected
// results come from a reference model and are queued at issue, then popped
// when done is seen.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model of one subtraction.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.d    = a - b;
    e.bout = (a < b);
    e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction

  // Call at a negedge: drives a one-cycle start and queues the expected result.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
    A     = a;
    B     = b;
    start = 1'b1;
    if (expect_it) exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Waits (bounded) for done, checks latency and scoreboard result.
  // Returns at the negedge inside the done cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= exp_lat + 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        lat  = i;
        seen = 1'b1;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (seen) begin
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check({tag, "_queue_nonempty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_D"}, 32'(D), 32'(e.d));
        check({tag, "_Bout"}, 32'(Bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_OVF"}, 32'(OVF), 32'(e.ovf));
`endif
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_D", 32'(D), 32'd0);
    check("reset_Bout", 32'(Bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_OVF", 32'(OVF), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic subtraction: 100 - 37 = 63
    start_op(8'd100, 8'd37, 1'b1);
    wait_done("basic", W);
    @(negedge clk);
    check("basic_done_width", 32'(done), 32'd0);

    // Borrow case, then back-to-back start issued in the done cycle
    start_op(8'h05, 8'h0A, 1'b1);
    wait_done("borrow", W);
    start_op(8'hFF, 8'hFF, 1'b1);
    check("b2b_done_cleared", 32'(done), 32'd0);
    wait_done("b2b_equal", W);
    @(negedge clk);

    // Start while busy is ignored
    start_op(8'h10, 8'h01, 1'b1);
    @(negedge clk);
    @(negedge clk);
    A     = 8'hAA;
    B     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_busy", W - 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("ignore_no_second_done", 32'(done), 32'd0);
    end
    check("ignore_idle", 32'(busy), 32'd0);

    // Reset mid-operation
    start_op(8'h33, 8'h11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_D", 32'(D), 32'd0);
    check("midrst_Bout", 32'(Bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    start_op(8'h09, 8'h03, 1'b1);
    wait_done("after_rst", W);

    // Hold and pulse width
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_done", 32'(done), 32'd0);
      check("hold_D", 32'(D), 32'h06);
      check("hold_Bout", 32'(Bout), 32'd0);
    end

    // Overflow cases (D/Bout checked always, OVF when the feature is built)
    start_op(8'h80, 8'h01, 1'b1);
    wait_done("ovf_neg_minus_pos", W);
    @(negedge clk);
    start_op(8'h7F, 8'hFF, 1'b1);
    wait_done("ovf_pos_minus_neg", W);
    @(negedge clk);
    start_op(8'h05, 8'h0A, 1'b1);
    wait_done("ovf_none", W);
    @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing D = A - B, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart of the combinational full adder.
- Accepts operands on a start strobe and returns the difference and final borrow with a one-cycle done pulse.
- Sits beside the adder blocks as the sequential, area-minimal arithmetic unit.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      request; sampled only while idle (busy=0)
- A      input   WIDTH  minuend, captured on the accepting edge
- B      input   WIDTH  subtrahend, captured on the accepting edge
- busy   output  1      high while an operation is in progress
- done   output  1      one-cycle pulse: D/Bout just updated
- D      output  WIDTH  difference, registered, held until the next completion
- Bout   output  1      final borrow out of the MSB (1 = A < B unsigned), held like D

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (rst). Assertion forces every register to 0 immediately: state=IDLE, busy=0, done=0, D=0, Bout=0.
- FSM states are IDLE and RUN. A WIDTH-sized bit counter (clog2 bits) and operand shift registers sa/sb/sd hold the work in progress.
- IDLE -> RUN:
  - Condition: start=1 at edge t.
  - Actions: sa<=A, sb<=B, borrow<=0, count<=0, busy<=1.
- RUN, each edge t+1..t+WIDTH, with a=sa[0], b=sb[0], bi=borrow:
  - d = a^b^bi; borrow <= (~a&b) | (~(a^b)&bi).
  - Shift d into sd from the MSB side; shift sa and sb right by 1; count++.
- RUN -> IDLE at edge t+WIDTH (last bit): D <= final sd, Bout <= final borrow, done <= 1, busy <= 0.
- Latency: done is high in the cycle after edge t+WIDTH. An operation occupies exactly WIDTH cycles after acceptance.
- done is high for exactly one cycle. It is cleared on the next edge unless a new completion occurs, which is impossible there.
- start while busy=1 is ignored. Operands are not re-sampled and there is no queueing.
- start in the same cycle that done=1 is accepted, since state is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- D and Bout change only at completion. During RUN they hold the previous result.
- Arithmetic is modulo 2^WIDTH. D equals the two's-complement difference; Bout equals unsigned borrow (A < B).
- Reset mid-RUN aborts the operation: no done pulse, D/Bout return to 0. The block is ready one edge after rst deasserts.
- A and B may change freely after the accepting edge.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port OVF (1 bit, reset 0) for signed overflow: borrow into the MSB XOR borrow out of the MSB.
  - It is captured on the last RUN edge and updated together with D/Bout.
- Undefined: port OVF and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8):
- Basic subtraction: rst pulse, then A=100, B=37, start for 1 cycle -> busy for 8 cycles; done pulses once; D=8'h3F (63), Bout=0.
- Borrow case: A=8'h05, B=8'h0A -> D=8'hFB, Bout=1. A=B=8'hFF -> D=8'h00, Bout=0. Issue the second start in the done cycle -> accepted; second done 9 cycles after the first.
- Start while busy: start with A=8'h10, B=8'h01, then start again 3 cycles later with A=8'hAA, B=8'h55 -> single done; D=8'h0F, Bout=0; the second request is ignored.
- Reset mid-operation: assert rst asynchronously 4 cycles into RUN -> busy, done, D, Bout all 0 immediately, no done pulse. A following A=8'h09, B=8'h03 -> D=8'h06.
- Hold and pulse width: after completion, hold start=0 for 20 cycles -> D/Bout stable, done high exactly 1 cycle.
- Overflow (SERIAL_SUB_OVF_EN):
  - A=8'h80, B=8'h01 -> D=8'h7F, Bout=0, OVF=1.
  - A=8'h7F, B=8'hFF -> D=8'h80, Bout=1, OVF=1.
  - A=8'h05, B=8'h0A -> OVF=0.
